my_display_driver: RTL

- Downstream consumer of the load/increment register's WIDTH-bit data_output.
- Converts the binary value to BCD with a sequential double-dabble engine.
- Time-multiplexes the BCD digits onto a common-anode seven-segment display with active-low segments and digit enables.
- Sits between the register and the board display pins.

---
 rtl/my_display_driver.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/my_display_driver.sv
// my_display_driver
//   Converts a WIDTH-bit binary value to BCD with a sequential double-dabble
//   engine. It then time-multiplexes the BCD digits onto a common-anode
//   seven-segment display. Segments and digit enables are active-low.
//
// Ports:
//   clk           system clock, all state on rising edge
//   asynch_reset  asynchronous active-high reset
//   data_input    binary value to display, sampled every cycle
//   bcd_output    latched BCD result, digit 0 (ones) in [3:0]
//   busy          high while a conversion is in progress
//   segments      active-low {g,f,e,d,c,b,a}
//   digit_enable  active-low one-hot digit select, bit0 = ones digit
//
// Conversion FSM:
//   state | meaning
//   IDLE  | waiting for data_input to differ from last_value
//   SHIFT | double-dabble shift/add-3 steps, one bit per cycle
//   DONE  | publish the working BCD to bcd_output
module my_display_driver #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  asynch_reset,
    input  logic [WIDTH-1:0]      data_input,
    output logic [4*DIGITS-1:0]   bcd_output,
    output logic                  busy,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_enable
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    // ceil(WIDTH * log10(2)) in integer arithmetic
    localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;

    generate
        if (DIGITS < MIN_DIGITS) begin : g_bad_digits
            $error("my_display_driver: DIGITS too small for WIDTH");
        end
        if (SCAN_DIV < 2) begin : g_bad_scan_div
            $error("my_display_driver: SCAN_DIV must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   last_value;
    logic [WIDTH-1:0]   snapshot;
    logic [BCD_W-1:0]   work_bcd;
    logic [BCD_W-1:0]   adj_bcd;
    logic [CNT_W-1:0]   shift_cnt;

    logic [PRE_W-1:0]   prescaler;
    logic [IDX_W-1:0]   scan_idx;
    logic [3:0]         cur_nib;
    logic [BCD_W-1:0]   upper_bcd;
    logic               blank;

    // Add-3 correction applied to every nibble before each shift
    always_comb begin
        adj_bcd = work_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_bcd[4*i +: 4] >= 4'd5) begin
                adj_bcd[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge asynch_reset) begin
        if (asynch_reset) begin
            state      <= IDLE;
            last_value <= '0;
            snapshot   <= '0;
            work_bcd   <= '0;
            shift_cnt  <= '0;
            bcd_output <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_input != last_value) begin
                        snapshot   <= data_input;
                        last_value <= data_input;
                        work_bcd   <= '0;
                        shift_cnt  <= '0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    {work_bcd, snapshot} <= {adj_bcd, snapshot} << 1;
                    shift_cnt            <= shift_cnt + CNT_W'(1);
                    if (shift_cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_output <= work_bcd;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Scan prescaler and digit index, free-running
    always_ff @(posedge clk or posedge asynch_reset) begin
        if (asynch_reset) begin
            prescaler <= '0;
            scan_idx  <= '0;
        end else if (prescaler == PRE_W'(SCAN_DIV - 1)) begin
            prescaler <= '0;
            if (scan_idx == IDX_W'(DIGITS - 1)) begin
                scan_idx <= '0;
            end else begin
                scan_idx <= scan_idx + IDX_W'(1);
            end
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b0111111;  // impossible nibble: g only
        endcase
    endfunction

    // A digit above the ones place is blanked when it and everything above it is zero
    always_comb begin
        cur_nib   = bcd_output[4*scan_idx +: 4];
        upper_bcd = bcd_output >> (4 * scan_idx);
        blank     = (scan_idx != '0) && (upper_bcd == '0);
    end

    always_ff @(posedge clk or posedge asynch_reset) begin
        if (asynch_reset) begin
            segments     <= 7'b1111111;
            digit_enable <= '1;
        end else begin
            digit_enable <= ~(DIGITS'(1) << scan_idx);
            segments     <= blank ? 7'b1111111 : seg7(cur_nib);
        end
    end

endmodule
